core_control_exception: RTL and testbench

CORE_CONTROL_EXCEPTION -- requirements
Module: core_control_exception

---
 rtl/core_control_exception_pkg.sv | 81 ++++++++
 rtl/core_control_exception_if.sv | 37 +++
 rtl/core_control_exception_arbiter.sv | 27 ++
 rtl/core_control_exception.sv | 129 ++++++++++++
 tb/tb_core_control_exception.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_control_exception_pkg.sv
// Shared core micro-architecture definitions: PSR modes, exception causes, vector offsets.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package core_control_exception_pkg;

    // Processor mode encodings as they appear in CPSR[4:0]
    typedef enum logic [4:0] {
        MODE_USR = 5'b10000,
        MODE_FIQ = 5'b10001,
        MODE_IRQ = 5'b10010,
        MODE_SVC = 5'b10011,
        MODE_ABT = 5'b10111,
        MODE_UND = 5'b11011,
        MODE_SYS = 5'b11111
    } psr_mode_t;

    // Exception causes; CAUSE_NONE marks an empty cause register
    typedef enum logic [2:0] {
        CAUSE_NONE = 3'd0,
        CAUSE_UND  = 3'd1,
        CAUSE_SWI  = 3'd2,
        CAUSE_PABT = 3'd3,
        CAUSE_DABT = 3'd4,
        CAUSE_IRQ  = 3'd5,
        CAUSE_FIQ  = 3'd6
    } exc_cause_t;

    // Vector table layout
    localparam logic [31:0] VEC_BASE_LOW  = 32'h0000_0000;
    localparam logic [31:0] VEC_BASE_HIGH = 32'hFFFF_0000;
    localparam logic [31:0] VEC_OFF_UND   = 32'h0000_0004;
    localparam logic [31:0] VEC_OFF_SWI   = 32'h0000_0008;
    localparam logic [31:0] VEC_OFF_PABT  = 32'h0000_000C;
    localparam logic [31:0] VEC_OFF_DABT  = 32'h0000_0010;
    localparam logic [31:0] VEC_OFF_IRQ   = 32'h0000_0018;
    localparam logic [31:0] VEC_OFF_FIQ   = 32'h0000_001C;

    // Bit positions of the sticky synchronous-exception pending vector
    localparam int PEND_W    = 4;
    localparam int PEND_UND  = 0;
    localparam int PEND_SWI  = 1;
    localparam int PEND_PABT = 2;
    localparam int PEND_DABT = 3;

    function automatic psr_mode_t cause_mode(input exc_cause_t c);
        case (c)
            CAUSE_DABT, CAUSE_PABT: return MODE_ABT;
            CAUSE_FIQ:              return MODE_FIQ;
            CAUSE_IRQ:              return MODE_IRQ;
            CAUSE_UND:              return MODE_UND;
            default:                return MODE_SVC;
        endcase
    endfunction

    function automatic logic [31:0] cause_offset(input exc_cause_t c);
        case (c)
            CAUSE_UND:  return VEC_OFF_UND;
            CAUSE_SWI:  return VEC_OFF_SWI;
            CAUSE_PABT: return VEC_OFF_PABT;
            CAUSE_DABT: return VEC_OFF_DABT;
            CAUSE_IRQ:  return VEC_OFF_IRQ;
            CAUSE_FIQ:  return VEC_OFF_FIQ;
            default:    return 32'h0000_0000;
        endcase
    endfunction

    // Pending bit retired when a cause is taken; interrupts are level and own no bit
    function automatic logic [PEND_W-1:0] cause_pend_mask(input exc_cause_t c);
        logic [PEND_W-1:0] m;
        m = '0;
        case (c)
            CAUSE_UND:  m[PEND_UND]  = 1'b1;
            CAUSE_SWI:  m[PEND_SWI]  = 1'b1;
            CAUSE_PABT: m[PEND_PABT] = 1'b1;
            CAUSE_DABT: m[PEND_DABT] = 1'b1;
            default:    m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/core_control_exception_if.sv
// Bundle between the pipeline/fetch side and the exception sequencer.
// Latency: n/a (wires only).
// Backpressure: branch is held by the sequencer until fetch returns branch_ack.
interface core_control_exception_if;
    import core_control_exception_pkg::*;

    logic        boundary;
    logic        undefined;
    logic        swi;
    logic        prefetch_abort;
    logic        data_abort;
    logic        irq;
    logic        fiq;
    logic [31:0] cpsr_rd;
    logic        branch_ack;

    logic        escalate;
    logic        exception;
    psr_mode_t   exception_mode;
    logic [31:0] vector;
    logic        branch;
    logic        busy;

    // Pipeline / fetch side
    modport master (
        output boundary, undefined, swi, prefetch_abort, data_abort,
        output irq, fiq, cpsr_rd, branch_ack,
        input  escalate, exception, exception_mode, vector, branch, busy
    );

    // Exception sequencer side
    modport slave (
        input  boundary, undefined, swi, prefetch_abort, data_abort,
        input  irq, fiq, cpsr_rd, branch_ack,
        output escalate, exception, exception_mode, vector, branch, busy
    );
endinterface

// File: rtl/core_control_exception_arbiter.sv
// Fixed-priority encoder from pending synchronous causes and eligible interrupts to one cause.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller decides whether the result is consumed this cycle.
module core_control_exception_arbiter
    import core_control_exception_pkg::*;
(
    input  logic [PEND_W-1:0] i_pend,
    input  logic              i_irq_ok,
    input  logic              i_fiq_ok,
    output logic              o_vld,
    output exc_cause_t        o_cause
);

    // Priority: data abort, fiq, irq, prefetch abort, undefined, swi
    always_comb begin
        o_vld   = 1'b1;
        o_cause = CAUSE_NONE;
        if (i_pend[PEND_DABT])      o_cause = CAUSE_DABT;
        else if (i_fiq_ok)          o_cause = CAUSE_FIQ;
        else if (i_irq_ok)          o_cause = CAUSE_IRQ;
        else if (i_pend[PEND_PABT]) o_cause = CAUSE_PABT;
        else if (i_pend[PEND_UND])  o_cause = CAUSE_UND;
        else if (i_pend[PEND_SWI])  o_cause = CAUSE_SWI;
        else                        o_vld   = 1'b0;
    end

endmodule

// File: rtl/core_control_exception.sv
// Exception sequencer: arbitrates causes at an instruction boundary and runs escalate/save/vector.
// Latency: cause arbitrated on cycle N -> escalate N+1, exception N+2, branch from N+3.
// Backpressure: branch/vector held until branch_ack; new causes while busy wait as pending.
module core_control_exception
    import core_control_exception_pkg::*;
#(
    parameter bit HIGH_VECTORS = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    core_control_exception_if.slave  bus
);

    localparam logic [31:0] VEC_BASE = HIGH_VECTORS ? VEC_BASE_HIGH : VEC_BASE_LOW;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ESCALATE = 2'd1,
        ST_SAVE     = 2'd2,
        ST_VECTOR   = 2'd3
    } state_t;

    state_t            r_state;
    exc_cause_t        r_cause;
    logic [PEND_W-1:0] r_pend;
    logic              r_escalate;
    logic              r_exception;
    logic              r_branch;
    logic [31:0]       r_vector;
    psr_mode_t         r_mode;

    logic [PEND_W-1:0] w_pulse;
    logic [PEND_W-1:0] w_pend_all;
    logic [PEND_W-1:0] w_clr;
    logic              w_irq_ok;
    logic              w_fiq_ok;
    logic              w_arb_vld;
    exc_cause_t        w_arb_cause;
    logic              w_take;
    logic              w_unused_cpsr;

    // A pulse arriving on the arbitration cycle competes directly, so it is merged before the encoder
    assign w_pulse[PEND_UND]  = bus.undefined;
    assign w_pulse[PEND_SWI]  = bus.swi;
    assign w_pulse[PEND_PABT] = bus.prefetch_abort;
    assign w_pulse[PEND_DABT] = bus.data_abort;
    assign w_pend_all         = r_pend | w_pulse;

    // Interrupts are level-sensitive and gated by the CPSR mask bits; never latched
    assign w_irq_ok      = bus.irq & ~bus.cpsr_rd[7];
    assign w_fiq_ok      = bus.fiq & ~bus.cpsr_rd[6];
    assign w_unused_cpsr = ^{bus.cpsr_rd[31:8], bus.cpsr_rd[5:0]};

    core_control_exception_arbiter u_arbiter (
        .i_pend   (w_pend_all),
        .i_irq_ok (w_irq_ok),
        .i_fiq_ok (w_fiq_ok),
        .o_vld    (w_arb_vld),
        .o_cause  (w_arb_cause)
    );

    assign w_take = (r_state == ST_IDLE) && bus.boundary && w_arb_vld;
    assign w_clr  = w_take ? cause_pend_mask(w_arb_cause) : '0;

    // Sticky pending bits: set by any pulse, retired only when that cause wins arbitration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_all & ~w_clr;
        end
    end

    // Sequencer FSM with registered strobes, mode and vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cause     <= CAUSE_NONE;
            r_escalate  <= 1'b0;
            r_exception <= 1'b0;
            r_branch    <= 1'b0;
            r_vector    <= '0;
            r_mode      <= MODE_SVC;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_state    <= ST_ESCALATE;
                        r_cause    <= w_arb_cause;
                        r_escalate <= 1'b1;
                        r_mode     <= cause_mode(w_arb_cause);
                    end
                end
                ST_ESCALATE: begin
                    r_state     <= ST_SAVE;
                    r_escalate  <= 1'b0;
                    r_exception <= 1'b1;
                end
                ST_SAVE: begin
                    r_state     <= ST_VECTOR;
                    r_exception <= 1'b0;
                    r_branch    <= 1'b1;
                    r_vector    <= VEC_BASE + cause_offset(r_cause);
                end
                ST_VECTOR: begin
                    if (bus.branch_ack) begin
                        // Mode returns to its reset value so IDLE always presents the same outputs
                        r_state  <= ST_IDLE;
                        r_cause  <= CAUSE_NONE;
                        r_branch <= 1'b0;
                        r_vector <= '0;
                        r_mode   <= MODE_SVC;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.escalate       = r_escalate;
    assign bus.exception      = r_exception;
    assign bus.branch         = r_branch;
    assign bus.vector         = r_vector;
    assign bus.exception_mode = r_mode;
    assign bus.busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_core_control_exception.sv
// Directed bench for the exception sequencer, low- and high-vector instances.
// Latency: checks each cycle at posedge+1 against hand-computed values.
// Backpressure: exercises branch hold with branch_ack delayed.
module tb_core_control_exception;
    import core_control_exception_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    core_control_exception_if u_if0 ();
    core_control_exception_if u_if1 ();

    core_control_exception #(.HIGH_VECTORS(1'b0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if0.slave)
    );

    core_control_exception #(.HIGH_VECTORS(1'b1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if1.slave)
    );

    function automatic logic [40:0] pk(input logic e, input logic x, input logic b, input logic y,
                                       input logic [4:0] m, input logic [31:0] v);
        return {e, x, b, y, m, v};
    endfunction

    task automatic chk(input string tag, input logic [40:0] obs, input logic [40:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed={esc,exc,br,busy,mode,vec}=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic e, input logic x, input logic b, input logic y,
                        input logic [4:0] m, input logic [31:0] v);
        chk(tag, {u_if0.escalate, u_if0.exception, u_if0.branch, u_if0.busy,
                  u_if0.exception_mode, u_if0.vector}, pk(e, x, b, y, m, v));
    endtask

    task automatic chk1(input string tag, input logic e, input logic x, input logic b, input logic y,
                        input logic [4:0] m, input logic [31:0] v);
        chk(tag, {u_if1.escalate, u_if1.exception, u_if1.branch, u_if1.busy,
                  u_if1.exception_mode, u_if1.vector}, pk(e, x, b, y, m, v));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0(input string tag);
        chk0(tag, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10011, 32'h0);
    endtask

    // Expects a sequence whose arbitration happens on the next edge.
    // waits: extra VECTOR cycles with branch_ack low; drop: {fiq,irq} to clear once taken;
    // inj_swi: pulse swi during the first branch cycle.
    task automatic seq0(input string tag, input logic [4:0] m, input logic [31:0] v,
                        input int waits, input logic [1:0] drop, input bit inj_swi);
        tick();
        u_if0.undefined      = 1'b0;
        u_if0.swi            = 1'b0;
        u_if0.prefetch_abort = 1'b0;
        u_if0.data_abort     = 1'b0;
        if (drop[1]) u_if0.fiq = 1'b0;
        if (drop[0]) u_if0.irq = 1'b0;
        chk0({tag, " esc"}, 1'b1, 1'b0, 1'b0, 1'b1, m, 32'h0);
        tick();
        chk0({tag, " exc"}, 1'b0, 1'b1, 1'b0, 1'b1, m, 32'h0);
        tick();
        chk0({tag, " br"}, 1'b0, 1'b0, 1'b1, 1'b1, m, v);
        if (inj_swi) u_if0.swi = 1'b1;
        for (int i = 0; i < waits; i++) begin
            tick();
            u_if0.swi = 1'b0;
            chk0({tag, " hold"}, 1'b0, 1'b0, 1'b1, 1'b1, m, v);
        end
        u_if0.branch_ack = 1'b1;
        tick();
        u_if0.branch_ack = 1'b0;
        if (inj_swi) u_if0.swi = 1'b0;
        idle0({tag, " ret"});
    endtask

    initial begin
        rst_n                = 1'b0;
        u_if0.boundary       = 1'b1;
        u_if0.undefined      = 1'b0;
        u_if0.swi            = 1'b0;
        u_if0.prefetch_abort = 1'b0;
        u_if0.data_abort     = 1'b0;
        u_if0.irq            = 1'b0;
        u_if0.fiq            = 1'b0;
        u_if0.cpsr_rd        = 32'h0;
        u_if0.branch_ack     = 1'b0;
        u_if1.boundary       = 1'b1;
        u_if1.undefined      = 1'b0;
        u_if1.swi            = 1'b0;
        u_if1.prefetch_abort = 1'b0;
        u_if1.data_abort     = 1'b0;
        u_if1.irq            = 1'b0;
        u_if1.fiq            = 1'b0;
        u_if1.cpsr_rd        = 32'h0;
        u_if1.branch_ack     = 1'b0;

        // Reset values
        tick();
        tick();
        idle0("reset dut0");
        chk1("reset dut1", 1'b0, 1'b0, 1'b0, 1'b0, 5'b10011, 32'h0);

        // Quiet after release
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            idle0("post reset idle");
        end

        // Undefined instruction, basic latency
        u_if0.undefined = 1'b1;
        seq0("und", 5'b11011, 32'h04, 0, 2'b00, 1'b0);

        // No boundary: swi stays pending, taken once boundary returns
        u_if0.boundary = 1'b0;
        u_if0.swi      = 1'b1;
        tick();
        u_if0.swi = 1'b0;
        idle0("no boundary a");
        tick();
        idle0("no boundary b");
        u_if0.boundary = 1'b1;
        seq0("swi pending", 5'b10011, 32'h08, 0, 2'b00, 1'b0);

        // Three synchronous causes at once, taken in priority order
        u_if0.undefined      = 1'b1;
        u_if0.swi            = 1'b1;
        u_if0.prefetch_abort = 1'b1;
        seq0("multi pabt", 5'b10111, 32'h0C, 0, 2'b00, 1'b0);
        seq0("multi und", 5'b11011, 32'h04, 0, 2'b00, 1'b0);
        seq0("multi swi", 5'b10011, 32'h08, 0, 2'b00, 1'b0);

        // fiq beats irq; irq still high afterwards
        u_if0.irq = 1'b1;
        u_if0.fiq = 1'b1;
        seq0("fiq first", 5'b10001, 32'h1C, 0, 2'b10, 1'b0);
        seq0("irq second", 5'b10010, 32'h18, 0, 2'b01, 1'b0);

        // irq masked by I bit, then unmasked
        u_if0.cpsr_rd = 32'h0000_0080;
        u_if0.irq     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            idle0("irq masked");
        end
        u_if0.cpsr_rd = 32'h0;
        seq0("irq unmasked", 5'b10010, 32'h18, 0, 2'b01, 1'b0);

        // irq that goes away before a boundary is dropped
        u_if0.boundary = 1'b0;
        u_if0.irq      = 1'b1;
        tick();
        u_if0.irq      = 1'b0;
        u_if0.boundary = 1'b1;
        idle0("irq transient a");
        tick();
        idle0("irq transient b");

        // F bit masks fiq but not irq
        u_if0.cpsr_rd = 32'h0000_0040;
        u_if0.fiq     = 1'b1;
        tick();
        idle0("fiq masked");
        u_if0.irq = 1'b1;
        seq0("irq over masked fiq", 5'b10010, 32'h18, 0, 2'b11, 1'b0);
        u_if0.cpsr_rd = 32'h0;

        // data abort beats irq; irq taken next
        u_if0.data_abort = 1'b1;
        u_if0.irq        = 1'b1;
        seq0("dabt over irq", 5'b10111, 32'h10, 0, 2'b00, 1'b0);
        seq0("irq after dabt", 5'b10010, 32'h18, 0, 2'b01, 1'b0);

        // swi during VECTOR with delayed ack; SVC follows
        u_if0.prefetch_abort = 1'b1;
        seq0("pabt held", 5'b10111, 32'h0C, 3, 2'b00, 1'b1);
        seq0("swi after hold", 5'b10011, 32'h08, 0, 2'b00, 1'b0);

        // High vectors, data abort
        u_if1.data_abort = 1'b1;
        tick();
        u_if1.data_abort = 1'b0;
        chk1("hv esc", 1'b1, 1'b0, 1'b0, 1'b1, 5'b10111, 32'h0);
        tick();
        chk1("hv exc", 1'b0, 1'b1, 1'b0, 1'b1, 5'b10111, 32'h0);
        tick();
        chk1("hv br", 1'b0, 1'b0, 1'b1, 1'b1, 5'b10111, 32'hFFFF_0010);
        u_if1.branch_ack = 1'b1;
        tick();
        u_if1.branch_ack = 1'b0;
        chk1("hv ret", 1'b0, 1'b0, 1'b0, 1'b0, 5'b10011, 32'h0);

        // Reset during SAVE with a swi pending
        u_if0.undefined = 1'b1;
        tick();
        u_if0.undefined = 1'b0;
        u_if0.swi       = 1'b1;
        chk0("mid esc", 1'b1, 1'b0, 1'b0, 1'b1, 5'b11011, 32'h0);
        tick();
        u_if0.swi = 1'b0;
        chk0("mid save", 1'b0, 1'b1, 1'b0, 1'b1, 5'b11011, 32'h0);
        rst_n = 1'b0;
        #1;
        idle0("mid reset async");
        tick();
        idle0("mid reset held");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            idle0("after mid reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
